// File: rtl/enc_pkg.sv
// Shared widths, mode constants and the combinational result bundle for the
// registered 8-to-3 encoder.
package enc_pkg;

    localparam int ENC_DATA_W    = 8;
    localparam int ENC_IDX_W     = 3;
    localparam int ENC_MODE_BF   = 0;
    localparam int ENC_MODE_PRIO = 1;

    typedef struct packed {
        logic [ENC_IDX_W-1:0] idx;
        logic                 any;
        logic                 onehot;
    } enc_res_t;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    function automatic logic is_onehot(input logic [ENC_DATA_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/encoder8to3_bf_core.sv
// Purely combinational 8-to-3 encoder core: OR-form or priority-form index,
// plus any-bit-set and one-hot indications.
module encoder8to3_bf_core
    import enc_pkg::*;
#(
    parameter int MODE = ENC_MODE_BF
) (
    input  logic [ENC_DATA_W-1:0] d,
    output logic [ENC_IDX_W-1:0]  idx,
    output logic                  any,
    output logic                  onehot
);

    logic [ENC_IDX_W-1:0] idx_bf;
    logic [ENC_IDX_W-1:0] idx_prio;

    assign idx_bf[0] = d[1] | d[3] | d[5] | d[7];
    assign idx_bf[1] = d[2] | d[3] | d[6] | d[7];
    assign idx_bf[2] = d[4] | d[5] | d[6] | d[7];

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        idx_prio = '0;
        for (int i = 0; i < ENC_DATA_W; i++) begin
            if (d[i]) idx_prio = ENC_IDX_W'(i);
        end
    end

    generate
        if (MODE == ENC_MODE_PRIO) begin : g_prio
            assign idx = idx_prio;
        end else begin : g_bf
            assign idx = idx_bf;
        end
    endgenerate

    assign any    = |d;
    assign onehot = is_onehot(d);

endmodule

// File: rtl/encoder8to3_bf_sync.sv
// Registered 8-to-3 encoder with capture enable, synchronous reset and
// validity/error flags; one cycle from d to o/valid/err.
module encoder8to3_bf_sync
    import enc_pkg::*;
#(
    parameter int MODE   = ENC_MODE_BF,
    parameter int DATA_W = ENC_DATA_W,
    parameter int IDX_W  = ENC_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [IDX_W-1:0]  o,
    output logic              valid,
    output logic              err
);

    generate
        if (DATA_W != ENC_DATA_W || IDX_W != ENC_IDX_W) begin : g_bad_cfg
            $error("encoder8to3_bf_sync: DATA_W must be 8 and IDX_W must be 3");
        end
        if (MODE != ENC_MODE_BF && MODE != ENC_MODE_PRIO) begin : g_bad_mode
            $error("encoder8to3_bf_sync: MODE must be 0 or 1");
        end
    endgenerate

    enc_res_t res;

    encoder8to3_bf_core #(
        .MODE   (MODE)
    ) u_core (
        .d      (d),
        .idx    (res.idx),
        .any    (res.any),
        .onehot (res.onehot)
    );

    // Reset wins over enable; with en low every output holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            o     <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else if (en) begin
            o     <= res.idx;
            valid <= res.any;
            err   <= ~res.onehot;
        end
    end

endmodule

// File: tb/tb_encoder8to3_bf_sync.sv
// Bench for encoder8to3_bf_sync: both modes side by side against a bit-counting
// reference model, directed scenarios followed by randomized traffic.
module tb_encoder8to3_bf_sync;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] d   = 8'h00;
    logic [2:0] o_bf, o_pr;
    logic       v_bf, v_pr, e_bf, e_pr;

    logic [2:0] x_o_bf, x_o_pr;
    logic       x_v, x_e;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    encoder8to3_bf_sync #(.MODE(0)) u_bf (
        .clk(clk), .rst(rst), .en(en), .d(d), .o(o_bf), .valid(v_bf), .err(e_bf)
    );
    encoder8to3_bf_sync #(.MODE(1)) u_pr (
        .clk(clk), .rst(rst), .en(en), .d(d), .o(o_pr), .valid(v_pr), .err(e_pr)
    );

    function automatic int popcount(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += v[i];
        return n;
    endfunction

    // OR of the indices of all set bits.
    function automatic logic [2:0] ref_bf(input logic [7:0] v);
        int acc = 0;
        for (int i = 0; i < 8; i++) if (v[i]) acc = acc | i;
        return 3'(acc);
    endfunction

    function automatic logic [2:0] ref_prio(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) if (v[i]) return 3'(i);
        return 3'd0;
    endfunction

    // Apply one clock of stimulus, advance the model, sample 1 time unit after the edge.
    task automatic step(input logic r, input logic e, input logic [7:0] dv);
        rst = r; en = e; d = dv;
        @(posedge clk);
        if (r) begin
            x_o_bf = 3'd0; x_o_pr = 3'd0; x_v = 1'b0; x_e = 1'b0;
        end else if (e) begin
            x_o_bf = ref_bf(dv);
            x_o_pr = ref_prio(dv);
            x_v    = (dv != 8'h00);
            x_e    = (popcount(dv) != 1);
        end
        #1;
    endtask

    task automatic test_reset;
        step(1'b1, 1'b1, 8'hFF);
        step(1'b1, 1'b1, 8'hFF);
        n_chk++;
        if ({o_bf, v_bf, e_bf, o_pr, v_pr, e_pr} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset: got bf o=%0d v=%0b e=%0b pr o=%0d v=%0b e=%0b, want all zero",
                     o_bf, v_bf, e_bf, o_pr, v_pr, e_pr);
        end
    endtask

    task automatic test_onehot_sweep;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] dv;
            dv = 8'h01 << i;
            step(1'b0, 1'b1, dv);
            n_chk++;
            if (o_bf !== 3'(i) || o_pr !== 3'(i) || v_bf !== 1'b1 || e_bf !== 1'b0
                || v_pr !== 1'b1 || e_pr !== 1'b0) begin
                n_fail++;
                $display("FAIL onehot_%0d: got bf o=%0d v=%0b e=%0b pr o=%0d v=%0b e=%0b, want o=%0d v=1 e=0",
                         i, o_bf, v_bf, e_bf, o_pr, v_pr, e_pr, i);
            end
        end
    endtask

    task automatic test_zero_hold;
        step(1'b0, 1'b1, 8'h20);
        n_chk++;
        if (o_bf !== 3'd5 || v_bf !== 1'b1 || e_bf !== 1'b0) begin
            n_fail++;
            $display("FAIL capture_20: got o=%0d v=%0b e=%0b, want o=5 v=1 e=0", o_bf, v_bf, e_bf);
        end
        step(1'b0, 1'b0, 8'h04);
        step(1'b0, 1'b0, 8'h04);
        n_chk++;
        if (o_bf !== 3'd5 || v_bf !== 1'b1 || e_bf !== 1'b0 || o_pr !== 3'd5) begin
            n_fail++;
            $display("FAIL en_hold: got bf o=%0d v=%0b e=%0b pr o=%0d, want o=5 v=1 e=0",
                     o_bf, v_bf, e_bf, o_pr);
        end
        step(1'b0, 1'b1, 8'h00);
        n_chk++;
        if (o_bf !== 3'd0 || v_bf !== 1'b0 || e_bf !== 1'b1 || o_pr !== 3'd0
            || v_pr !== 1'b0 || e_pr !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_in: got bf o=%0d v=%0b e=%0b pr o=%0d v=%0b e=%0b, want o=0 v=0 e=1",
                     o_bf, v_bf, e_bf, o_pr, v_pr, e_pr);
        end
    endtask

    task automatic test_multihot;
        step(1'b0, 1'b1, 8'h12);
        n_chk++;
        if (o_bf !== 3'b101 || v_bf !== 1'b1 || e_bf !== 1'b1) begin
            n_fail++;
            $display("FAIL multi_12_bf: got o=%0d v=%0b e=%0b, want o=5 v=1 e=1", o_bf, v_bf, e_bf);
        end
        n_chk++;
        if (o_pr !== 3'b100 || v_pr !== 1'b1 || e_pr !== 1'b1) begin
            n_fail++;
            $display("FAIL multi_12_prio: got o=%0d v=%0b e=%0b, want o=4 v=1 e=1", o_pr, v_pr, e_pr);
        end
        step(1'b0, 1'b1, 8'hC0);
        n_chk++;
        if (o_pr !== 3'd7 || e_pr !== 1'b1 || o_bf !== 3'd7 || e_bf !== 1'b1) begin
            n_fail++;
            $display("FAIL multi_C0: got bf o=%0d e=%0b pr o=%0d e=%0b, want o=7 e=1",
                     o_bf, e_bf, o_pr, e_pr);
        end
    endtask

    task automatic test_reset_midstream;
        step(1'b0, 1'b1, 8'h02);
        step(1'b1, 1'b1, 8'h80);
        n_chk++;
        if (o_bf !== 3'd0 || v_bf !== 1'b0 || e_bf !== 1'b0 || o_pr !== 3'd0 || v_pr !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got bf o=%0d v=%0b e=%0b pr o=%0d v=%0b, want o=0 v=0 e=0",
                     o_bf, v_bf, e_bf, o_pr, v_pr);
        end
        step(1'b0, 1'b1, 8'h80);
        n_chk++;
        if (o_bf !== 3'd7 || v_bf !== 1'b1 || e_bf !== 1'b0 || o_pr !== 3'd7) begin
            n_fail++;
            $display("FAIL rst_release: got bf o=%0d v=%0b e=%0b pr o=%0d, want o=7 v=1 e=0",
                     o_bf, v_bf, e_bf, o_pr);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 400; n++) begin
            logic [7:0] dv;
            logic       r, e;
            case ($urandom_range(0, 3))
                0:       dv = 8'h01 << $urandom_range(0, 7);
                1:       dv = 8'h00;
                default: dv = 8'($urandom);
            endcase
            r = ($urandom_range(0, 19) == 0);
            e = ($urandom_range(0, 3) != 0);
            step(r, e, dv);
            n_chk++;
            if (o_bf !== x_o_bf || o_pr !== x_o_pr || v_bf !== x_v || v_pr !== x_v
                || e_bf !== x_e || e_pr !== x_e) begin
                n_fail++;
                $display("FAIL random_%0d: d=%h rst=%0b en=%0b got bf o=%0d v=%0b e=%0b pr o=%0d v=%0b e=%0b, want bf o=%0d pr o=%0d v=%0b e=%0b",
                         n, dv, r, e, o_bf, v_bf, e_bf, o_pr, v_pr, e_pr, x_o_bf, x_o_pr, x_v, x_e);
            end
        end
    endtask

    initial begin
        x_o_bf = 3'd0; x_o_pr = 3'd0; x_v = 1'b0; x_e = 1'b0;
        @(negedge clk);
        test_reset;
        test_onehot_sweep;
        test_zero_hold;
        test_multihot;
        test_reset_midstream;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/encoder8to3_bf_sync.md
Name: encoder8to3_bf_sync

Overview:
- Registered 8-to-3 binary encoder.
- A one-hot 8-bit input is encoded to its 3-bit bit index. Sum-of-products ("boolean function") form is the default; a priority form is selectable.
- Adds input-validity and error flags.
- Sits between one-hot select/request sources and index-consuming datapath logic. The encoded index is registered once on the system clock.

Parameters:
- MODE, 0, encoding form:
  - 0 = boolean-function (OR) form: o[0]=d1|d3|d5|d7, o[1]=d2|d3|d6|d7, o[2]=d4|d5|d6|d7.
  - 1 = priority form: index of the highest set bit wins.
- DATA_W, 8, input width; fixed at 8. Any other value is a configuration error flagged at elaboration.
- IDX_W, 3, output index width; fixed at 3.

Ports:
- clk, input, 1, system clock; rising-edge active.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, capture enable. When 0, all outputs hold.
- d, input, 8, one-hot input vector.
- o, output, 3, encoded index (registered).
- valid, output, 1, registered: captured d had at least one bit set.
- err, output, 1, registered: captured d was not one-hot (zero or multi-hot).

Behaviour:
- Reset:
  - Synchronous, sampled on the rising clk edge only.
  - While rst=1 at an edge: o=3'b000, valid=0, err=0.
  - rst overrides en.
  - Reset asserted mid-stream clears outputs at the next edge; the pending capture is discarded.
- Latency: 1 cycle. A d value sampled at edge N with en=1 appears on o/valid/err after edge N. No combinational path from d to outputs.
- en=0: o, valid and err hold their previous values.
- One-hot d (exactly one bit k set): o=k, valid=1, err=0, in both modes.
  - 8'h01→0, 8'h02→1, 8'h04→2, 8'h08→3, 8'h10→4, 8'h20→5, 8'h40→6, 8'h80→7.
- d=8'h00: o=3'b000, valid=0, err=1.
- Multi-hot d (≥2 bits set): valid=1, err=1.
  - MODE=0: o is the bitwise OR of the set bits' indices. Example: 8'h12 (bits 1,4) → 3'b101.
  - MODE=1: o is the index of the highest set bit. Example: 8'h12 → 3'b100.
- One-hot detection: d!=0 and (d & (d-1))==0; computed combinationally before the register stage.
- No handshake, no backpressure. Every enabled cycle captures.

Decomposition:
- Package enc_pkg: localparams ENC_DATA_W=8, ENC_IDX_W=3; mode constants ENC_MODE_BF=0, ENC_MODE_PRIO=1.
- Sub-module encoder8to3_bf_core: purely combinational.
  - Inputs: d, MODE.
  - Outputs: idx[2:0], any, onehot.
- The top-level encoder8to3_bf_sync instantiates the core and adds the registers, enable, reset and flag logic.

Test Plan:
- Reset: rst=1 for 2 cycles with d=8'hFF, en=1 → o=0, valid=0, err=0. Then release rst.
- One-hot sweep, en=1, MODE=0: d=8'h01,8'h02,…,8'h80, each held 1 cycle → one cycle later o=0,1,…,7, valid=1, err=0 each cycle.
- Zero and enable-hold:
  - d=8'h20 captured → o=5.
  - Then en=0 with d=8'h04 → o stays 5, valid=1, err=0.
  - Then en=1 with d=8'h00 → o=0, valid=0, err=1.
- Multi-hot d=8'h12:
  - MODE=0 → o=3'b101, valid=1, err=1.
  - MODE=1 → o=3'b100, valid=1, err=1.
- Multi-hot d=8'hC0, MODE=1 → o=7, err=1.
- Reset mid-stream: d=8'h80, en=1, rst=1 at the same edge → o=0, valid=0 after that edge. Next edge with rst=0 → o=7, valid=1.
